registrador_deslocamento_universal: RTL
=======================================

Name: registrador_deslocamento_universal

Overview:
Parametrised universal shift register, the successor to the fixed 4-bit serial-in shift register.
- Generalises width and adds selectable shift direction, rotate, parallel load, clock enable and synchronous clear.
- Adds a shifted-out serial bit and a word-complete counter, so the block works as a serial-to-parallel deserialiser or a parallel-to-serial serialiser inside datapath and communication projects.

Parameters:
- WIDTH, 4: register width in bits; minimum 2.
- RESET_VALUE, 0: value loaded into q on reset (WIDTH bits).
- Derived localparam CW = clog2(WIDTH+1): width of the internal shift counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- clear  in  1  synchronous clear, active-high
- enable  in  1  clock enable for load/shift operations
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
- rotate  in  1  1 = in shift modes, feed the wrapped bit instead of serial_in
- serial_in  in  1  serial data input
- data_in  in  WIDTH  parallel load value
- q  out  WIDTH  register contents
- serial_out  out  1  registered copy of the bit last shifted out
- word_ready  out  1  one-cycle pulse: WIDTH shifts completed since last load/clear/wrap

Behaviour:
- Reset (reset=0, asynchronous, immediate, no clock needed):
  - q=RESET_VALUE, serial_out=0, word_ready=0, counter=0.
  - Holds while reset=0; normal operation resumes on the first rising edge after release.
- Priority per rising edge: reset > clear > enable gating > mode.
- clear=1: q=0, serial_out=0, word_ready=0, counter=0, regardless of enable and mode.
- enable=0: q, serial_out and counter hold; word_ready=0.
- enable=1, mode 00 (hold): q holds, counter holds, word_ready=0.
- enable=1, mode 01 (shift right):
  - q[WIDTH-1] <= (rotate ? q[0] : serial_in); q[i] <= q[i+1].
  - serial_out <= q[0].
- enable=1, mode 10 (shift left):
  - q[0] <= (rotate ? q[WIDTH-1] : serial_in); q[i] <= q[i-1].
  - serial_out <= q[WIDTH-1].
- enable=1, mode 11 (load): q <= data_in; counter=0; serial_out holds; word_ready=0.
- All q updates are simultaneous (non-blocking semantics); no intermediate values are visible.
- Counter rules:
  - Increments on every enabled shift (modes 01/10, rotate or not).
  - On a shift with counter == WIDTH-1: counter wraps to 0 and word_ready=1 for exactly the following cycle.
  - Otherwise word_ready=0.
- Direction change mid-word does not reset the counter.
- Latency: one clock from inputs to q/serial_out/word_ready.
- Reset asserted mid-word discards partial progress; the first word after release needs a full WIDTH shifts.

Test Plan:
- WIDTH=4, q=1011, assert reset=0 between edges -> q=0000, word_ready=0 immediately; release, no edge -> still 0000.
- From 0000, enable=1, mode=01, rotate=0, serial_in=1,0,0,0 over 4 edges -> q=1000,0100,0010,0001; word_ready=1 only in the cycle after edge 4; serial_out stays 0.
- Load data_in=1011 (mode 11) -> q=1011.
  - Then mode=10, rotate=1, one edge -> q=0111, serial_out=1.
  - Reload 1011, mode=01, rotate=1, one edge -> q=1101, serial_out=1.
- q=0110, enable=0 with mode=01 for 3 edges -> q=0110, no word_ready; enable=1, mode=00 for 5 edges -> q=0110, counter unchanged, no word_ready.
- 2 shifts, then clear=1 for one edge -> q=0000, serial_out=0; word_ready next appears only after 4 further shifts, not 2.
- clear=1 together with enable=1, mode=11, data_in=1111 -> q=0000 (clear wins); 3 shifts then a load, then 4 shifts -> word_ready after the 4th shift following the load only.

Source files
------------

// File: rtl/registrador_deslocamento_universal.sv
// Universal shift register: hold, shift right/left with optional rotate, parallel load and word-complete pulse.
// Latency one clock from inputs to q/serial_out/word_ready; no backpressure, enable=0 simply stalls the register.
module registrador_deslocamento_universal #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             rotate,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             word_ready
);

    localparam int            CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count;
    logic          shift_right;
    logic          shift_left;
    logic          shifting;
    logic          fill_right;
    logic          fill_left;

    always_comb begin
        shift_right = enable && (mode == 2'b01);
        shift_left  = enable && (mode == 2'b10);
        shifting    = shift_right || shift_left;
        // Bit entering the vacated end: wrapped bit when rotating, else serial input.
        fill_right  = rotate ? q[0]       : serial_in;
        fill_left   = rotate ? q[WIDTH-1] : serial_in;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q          <= RESET_VALUE;
            serial_out <= 1'b0;
            word_ready <= 1'b0;
            count      <= '0;
        end else if (clear) begin
            q          <= '0;
            serial_out <= 1'b0;
            word_ready <= 1'b0;
            count      <= '0;
        end else begin
            word_ready <= 1'b0;
            if (shift_right) begin
                q          <= {fill_right, q[WIDTH-1:1]};
                serial_out <= q[0];
            end else if (shift_left) begin
                q          <= {q[WIDTH-2:0], fill_left};
                serial_out <= q[WIDTH-1];
            end else if (enable && (mode == 2'b11)) begin
                q          <= data_in;
                count      <= '0;
            end
            // Direction changes mid-word keep counting toward the same word boundary.
            if (shifting) begin
                if (count == COUNT_LAST) begin
                    count      <= '0;
                    word_ready <= 1'b1;
                end else begin
                    count      <= count + 1'b1;
                end
            end
        end
    end

endmodule
